// File: rtl/scs8hd_latch_wr_sched_if.sv
// Write-port and latch-array bundle for the latch write scheduler.
// The slave side is the scheduler; the master side is the requester/latch environment.
interface scs8hd_latch_wr_sched_if #(
  parameter int NWORDS = 8,
  parameter int AW     = 3,
  parameter int DW     = 8
);
  logic [1:0]        req;
  logic [AW-1:0]     addr0;
  logic [DW-1:0]     data0;
  logic [AW-1:0]     addr1;
  logic [DW-1:0]     data1;
  logic [1:0]        ack;
  logic              err;
  logic              busy;
  logic [DW-1:0]     lat_d;
  logic [NWORDS-1:0] lat_gaten;

  modport master (
    output req, addr0, data0, addr1, data1,
    input  ack, err, busy, lat_d, lat_gaten
  );

  modport slave (
    input  req, addr0, data0, addr1, data1,
    output ack, err, busy, lat_d, lat_gaten
  );
endinterface

// File: rtl/scs8hd_latch_wr_sched.sv
// Round-robin write scheduler for an active-low-gate latch bank; sequences
// setup / open / hold phases so latch timing is met by construction.
//
// state   | meaning
// S_IDLE  | no write in flight; arbitrate REQ and capture the winner
// S_SETUP | LAT_D driven with captured data, all gates closed
// S_OPEN  | gate of the addressed word low (none if address out of range)
// S_HOLD  | gates closed, data held; ACK/ERR in the last cycle
module scs8hd_latch_wr_sched #(
  parameter int NWORDS    = 8,
  parameter int AW        = 3,
  parameter int DW        = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input logic                     clk_i,
  input logic                     rst_n_i,
  scs8hd_latch_wr_sched_if.slave  bus
);

  localparam int MAXC = (SETUP_CYC > PULSE_CYC)
                        ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                        : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int CW = $clog2(MAXC) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_OPEN, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [DW-1:0]     lat_d_q, lat_d_d;
  logic [NWORDS-1:0] gaten_q, gaten_d;
  logic [1:0]        ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              pick;
  logic              in_range;

  assign in_range = (int'(addr_q) < NWORDS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    lat_d_d = lat_d_q;
    pick    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req != 2'b00) begin
          pick    = (bus.req == 2'b11) ? ~last_q : bus.req[1];
          gnt_d   = pick;
          last_d  = pick;
          addr_d  = pick ? bus.addr1 : bus.addr0;
          lat_d_d = pick ? bus.data1 : bus.data0;
          state_d = S_SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_OPEN;
          cnt_d   = CW'(PULSE_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_OPEN: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so every latch-facing pin is a flop.
    gaten_d = '1;
    if (state_d == S_OPEN) begin
      for (int i = 0; i < NWORDS; i++) begin
        if (addr_q == AW'(i)) gaten_d[i] = 1'b0;
      end
    end

    ack_d = 2'b00;
    err_d = 1'b0;
    if (state_d == S_HOLD && cnt_d == '0) begin
      ack_d = gnt_q ? 2'b10 : 2'b01;
      err_d = ~in_range;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      lat_d_q <= '0;
      gaten_q <= '1;
      ack_q   <= 2'b00;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      lat_d_q <= lat_d_d;
      gaten_q <= gaten_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.lat_gaten = gaten_q;
  assign bus.lat_d     = lat_d_q;
  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_scs8hd_latch_wr_sched.sv
// Bench for scs8hd_latch_wr_sched: two instances (default timing, and a
// 6-word bank with stretched phases) checked against a transaction-level model.
module tb_scs8hd_latch_wr_sched;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int NW_A = 8, S_A = 1, P_A = 2, H_A = 1;
  localparam int NW_B = 6, S_B = 2, P_B = 1, H_B = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scs8hd_latch_wr_sched_if #(.NWORDS(NW_A), .AW(AW), .DW(DW)) bus_a ();
  scs8hd_latch_wr_sched_if #(.NWORDS(NW_B), .AW(AW), .DW(DW)) bus_b ();

  scs8hd_latch_wr_sched #(.NWORDS(NW_A), .AW(AW), .DW(DW),
                          .SETUP_CYC(S_A), .PULSE_CYC(P_A), .HOLD_CYC(H_A))
    dut_a (.clk_i(clk), .rst_n_i(rst_n), .bus(bus_a));

  scs8hd_latch_wr_sched #(.NWORDS(NW_B), .AW(AW), .DW(DW),
                          .SETUP_CYC(S_B), .PULSE_CYC(P_B), .HOLD_CYC(H_B))
    dut_b (.clk_i(clk), .rst_n_i(rst_n), .bus(bus_b));

  logic [1:0]    req_v  [2];
  logic [AW-1:0] addr_v [2][2];
  logic [DW-1:0] data_v [2][2];

  assign bus_a.req   = req_v[0];
  assign bus_a.addr0 = addr_v[0][0];
  assign bus_a.addr1 = addr_v[0][1];
  assign bus_a.data0 = data_v[0][0];
  assign bus_a.data1 = data_v[0][1];
  assign bus_b.req   = req_v[1];
  assign bus_b.addr0 = addr_v[1][0];
  assign bus_b.addr1 = addr_v[1][1];
  assign bus_b.data0 = data_v[1][0];
  assign bus_b.data1 = data_v[1][1];

  logic [1:0] ack_w   [2];
  logic       err_w   [2];
  logic       busy_w  [2];
  logic [7:0] latd_w  [2];
  logic [7:0] gaten_w [2];

  assign ack_w[0]   = bus_a.ack;
  assign err_w[0]   = bus_a.err;
  assign busy_w[0]  = bus_a.busy;
  assign latd_w[0]  = bus_a.lat_d;
  assign gaten_w[0] = bus_a.lat_gaten;
  assign ack_w[1]   = bus_b.ack;
  assign err_w[1]   = bus_b.err;
  assign busy_w[1]  = bus_b.busy;
  assign latd_w[1]  = bus_b.lat_d;
  assign gaten_w[1] = {2'b11, bus_b.lat_gaten};

  // Model: a write accepted on an edge occupies cycles 1..S+P+H after it.
  int nw [2] = '{NW_A, NW_B};
  int sc [2] = '{S_A, S_B};
  int pc [2] = '{P_A, P_B};
  int hc [2] = '{H_A, H_B};

  bit         m_active [2];
  int         m_k      [2];
  bit         m_who    [2];
  int         m_addr   [2];
  logic [7:0] m_data   [2];
  bit         m_last   [2];
  bit         m_gnow   [2];
  int         drv_st   [2][2];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int lat(int k);
    return sc[k] + pc[k] + hc[k];
  endfunction

  function automatic logic [1:0] e_ack(int k);
    if (m_active[k] && m_k[k] == lat(k)) return m_who[k] ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic logic e_err(int k);
    return (e_ack(k) != 2'b00) && (m_addr[k] >= nw[k]);
  endfunction

  function automatic logic [7:0] e_gaten(int k);
    logic [7:0] g;
    g = 8'hFF;
    if (m_active[k] && m_k[k] > sc[k] && m_k[k] <= sc[k] + pc[k] && m_addr[k] < nw[k])
      g[m_addr[k]] = 1'b0;
    return g;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 1'b0;
      m_k[k]      = 0;
      m_who[k]    = 1'b0;
      m_addr[k]   = 0;
      m_data[k]   = 8'h00;
      m_last[k]   = 1'b1;
      m_gnow[k]   = 1'b0;
    end
  endtask

  task automatic model_step(int k);
    m_gnow[k] = 1'b0;
    if (m_active[k]) begin
      if (m_k[k] == lat(k)) m_active[k] = 1'b0;
      else m_k[k] = m_k[k] + 1;
    end else if (req_v[k] != 2'b00) begin
      m_who[k]    = (req_v[k] == 2'b11) ? !m_last[k] : req_v[k][1];
      m_last[k]   = m_who[k];
      m_addr[k]   = int'(addr_v[k][m_who[k]]);
      m_data[k]   = data_v[k][m_who[k]];
      m_active[k] = 1'b1;
      m_k[k]      = 1;
      m_gnow[k]   = 1'b1;
    end
  endtask

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %0h, expected %0h", nm, k, $time, act, exp);
    end
  endtask

  task automatic compare(int k);
    chk("ack",   k, 32'(ack_w[k]),   32'(e_ack(k)));
    chk("err",   k, 32'(err_w[k]),   32'(e_err(k)));
    chk("busy",  k, 32'(busy_w[k]),  32'(m_active[k]));
    chk("lat_d", k, 32'(latd_w[k]),  32'(m_data[k]));
    chk("gaten", k, 32'(gaten_w[k]), 32'(e_gaten(k)));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      model_step(k);
      compare(k);
    end
  endtask

  task automatic drive_random();
    logic [1:0] ea;
    for (int k = 0; k < 2; k++) begin
      ea = e_ack(k);
      for (int j = 0; j < 2; j++) begin
        if (m_gnow[k] && int'(m_who[k]) == j) begin
          drv_st[k][j] = 2;
        end else if (ea[j]) begin
          if ($urandom_range(1) == 1) begin
            drv_st[k][j] = 1;
            req_v[k][j]  = 1'b1;
            addr_v[k][j] = AW'($urandom_range(7));
            data_v[k][j] = DW'($urandom);
          end else begin
            drv_st[k][j] = 0;
            req_v[k][j]  = 1'b0;
          end
        end else begin
          case (drv_st[k][j])
            0: begin
              addr_v[k][j] = AW'($urandom_range(7));
              data_v[k][j] = DW'($urandom);
              if ($urandom_range(3) == 0) begin
                drv_st[k][j] = 1;
                req_v[k][j]  = 1'b1;
              end else begin
                req_v[k][j] = 1'b0;
              end
            end
            2: begin
              // Granted: anything on the port now must be ignored by the DUT.
              req_v[k][j]  = 1'($urandom_range(1));
              addr_v[k][j] = AW'($urandom_range(7));
              data_v[k][j] = DW'($urandom);
            end
            default: ;
          endcase
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      req_v[k] = 2'b00;
      for (int j = 0; j < 2; j++) begin
        addr_v[k][j] = '0;
        data_v[k][j] = '0;
        drv_st[k][j] = 0;
      end
    end
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) compare(k);
    chk("rst_gaten", 0, 32'(gaten_w[0]), 32'h0000_00FF);
    chk("rst_busy",  0, 32'(busy_w[0]),  32'h0);
    rst_n = 1'b1;

    // Contention on A from reset; stretched-phase write to word 4 on B.
    req_v[0] = 2'b11;
    addr_v[0][0] = 3'd1; data_v[0][0] = 8'h11;
    addr_v[0][1] = 3'd2; data_v[0][1] = 8'h22;
    req_v[1] = 2'b01;
    addr_v[1][0] = 3'd4; data_v[1][0] = 8'h5A;
    for (int c = 1; c <= 10; c++) begin
      cycle();
      chk("lit_cont_gaten", 0, 32'(gaten_w[0]),
          (c == 2 || c == 3) ? 32'hFD : (c == 7 || c == 8) ? 32'hFB : 32'hFF);
      chk("lit_cont_ack", 0, 32'(ack_w[0]), (c == 4) ? 32'h1 : (c == 9) ? 32'h2 : 32'h0);
      chk("lit_cont_busy", 0, 32'(busy_w[0]), (c != 5 && c != 10) ? 32'h1 : 32'h0);
      chk("lit_cont_latd", 0, 32'(latd_w[0]), (c < 6) ? 32'h11 : 32'h22);
      chk("lit_sweep_gaten", 1, 32'(gaten_w[1]), (c == 3) ? 32'hEF : 32'hFF);
      chk("lit_sweep_ack", 1, 32'(ack_w[1]), (c == 6) ? 32'h1 : 32'h0);
      chk("lit_sweep_latd", 1, 32'(latd_w[1]), 32'h5A);
      if (c == 4) req_v[0] = 2'b10;
      if (c == 9) req_v[0] = 2'b00;
      if (c == 6) req_v[1] = 2'b00;
    end

    // Single write to word 5 on A; out-of-range write (word 7 of 6) on B.
    req_v[0] = 2'b01;
    addr_v[0][0] = 3'd5; data_v[0][0] = 8'hA5;
    req_v[1] = 2'b10;
    addr_v[1][1] = 3'd7; data_v[1][1] = 8'h3C;
    for (int c = 1; c <= 7; c++) begin
      cycle();
      chk("lit_single_gaten", 0, 32'(gaten_w[0]), (c == 2 || c == 3) ? 32'hDF : 32'hFF);
      chk("lit_single_ack", 0, 32'(ack_w[0]), (c == 4) ? 32'h1 : 32'h0);
      chk("lit_single_busy", 0, 32'(busy_w[0]), (c <= 4) ? 32'h1 : 32'h0);
      chk("lit_single_latd", 0, 32'(latd_w[0]), 32'hA5);
      chk("lit_oor_gaten", 1, 32'(gaten_w[1]), 32'hFF);
      chk("lit_oor_ack", 1, 32'(ack_w[1]), (c == 6) ? 32'h2 : 32'h0);
      chk("lit_oor_err", 1, 32'(err_w[1]), (c == 6) ? 32'h1 : 32'h0);
      if (c == 4) req_v[0] = 2'b00;
      if (c == 6) req_v[1] = 2'b00;
    end

    for (int n = 0; n < 4000; n++) begin
      cycle();
      drive_random();
    end

    for (int k = 0; k < 2; k++) begin
      req_v[k] = 2'b00;
      for (int j = 0; j < 2; j++) drv_st[k][j] = 0;
    end
    for (int g = 0; g < 20 && (m_active[0] || m_active[1]); g++) cycle();
    chk("drain_busy", 0, 32'(busy_w[0] | busy_w[1]), 32'h0);

    // Reset while word 3's gate is open; REQ is dropped early on purpose.
    req_v[0] = 2'b01;
    addr_v[0][0] = 3'd3; data_v[0][0] = 8'h77;
    cycle();
    req_v[0] = 2'b00;
    cycle();
    chk("lit_rst_open_gaten", 0, 32'(gaten_w[0]), 32'hF7);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_async_gaten", 0, 32'(gaten_w[0]), 32'hFF);
    chk("lit_async_latd",  0, 32'(latd_w[0]),  32'h0);
    chk("lit_async_busy",  0, 32'(busy_w[0]),  32'h0);
    chk("lit_async_ack",   0, 32'(ack_w[0]),   32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 10; c++) begin
      cycle();
      chk("lit_no_ack_after_rst", 0, 32'(ack_w[0]), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
